// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the 3-byte SPI command frame: frame and byte widths,
// counter widths and the master FSM state type. The frame receiver imports
// FRAME_BITS from here so both ends always agree on the frame length.
// -----------------------------------------------------------------------------
package spi_pkg;

  localparam int FRAME_BITS    = 24;
  localparam int BYTE_BITS     = 8;
  localparam int HALF_CNT_BITS = 8;  // holds CLK_DIV-1 for CLK_DIV up to 255
  localparam int BIT_CNT_BITS  = 5;  // holds bit index 0..FRAME_BITS-1

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } spi_master_state_t;

endpackage

// File: rtl/spi_sck_gen.sv
// -----------------------------------------------------------------------------
// spi_sck_gen
// Serial clock generator for the SPI frame master. While en is high it runs a
// half-period counter 0..CLK_DIV-1 and toggles sck each time the counter
// wraps, starting from the low half. rise_en / fall_en are one-cycle strobes
// in the cycle whose closing clock edge takes sck high / low. With en low the
// counter and sck are held at 0 so every frame starts on a fresh low half.
//
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   en       in   run the serial clock (master is in SHIFT)
//   sck      out  registered serial clock, idle low
//   rise_en  out  sck goes 1 at the next clock edge
//   fall_en  out  sck goes 0 at the next clock edge
// -----------------------------------------------------------------------------
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sck,
  output logic rise_en,
  output logic fall_en
);

  localparam logic [HALF_CNT_BITS-1:0] HALF_LAST = HALF_CNT_BITS'(CLK_DIV - 1);

  logic [HALF_CNT_BITS-1:0] half_cnt_q, half_cnt_d;
  logic                     sck_q, sck_d;
  logic                     wrap;

  assign wrap = en && (half_cnt_q == HALF_LAST);

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    half_cnt_d = '0;
    sck_d      = 1'b0;
    if (en) begin
      half_cnt_d = wrap ? '0 : half_cnt_q + 1'b1;
      sck_d      = wrap ? ~sck_q : sck_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      half_cnt_q <= '0;
      sck_q      <= 1'b0;
    end else begin
      half_cnt_q <= half_cnt_d;
      sck_q      <= sck_d;
    end
  end

  assign sck     = sck_q;
  assign rise_en = wrap && !sck_q;
  assign fall_en = wrap &&  sck_q;

endmodule

// File: rtl/spi_frame_master.sv
// -----------------------------------------------------------------------------
// spi_frame_master
// Mode-0 SPI master that sends one 24-bit command frame
// {command, databyte1, databyte2} MSB first and captures the 24 bits returned
// on sdo. A frame is accepted on req && ready, shifted out over 24 sck
// periods of 2*CLK_DIV clk cycles each, followed by CLK_DIV cycles of hold
// with cs still high. done pulses for one cycle as the master returns to
// IDLE, and rx_frame is updated at that same point.
//
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset (aborts any frame)
//   req        in   frame request, accepted when ready is high
//   command    in   first byte sent
//   databyte1  in   second byte sent
//   databyte2  in   third byte sent
//   ready      out  master is idle and will accept req
//   done       out  one-cycle pulse at frame completion
//   rx_frame   out  captured sdo bits, first-received bit at [23]
//   cs         out  chip select, high for the whole frame
//   sck        out  serial clock, idle low
//   sdi        out  serial data to the receiver, MSB first
//   sdo        in   serial data from the receiver
// -----------------------------------------------------------------------------
module spi_frame_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic [BYTE_BITS-1:0]  command,
  input  logic [BYTE_BITS-1:0]  databyte1,
  input  logic [BYTE_BITS-1:0]  databyte2,
  output logic                  ready,
  output logic                  done,
  output logic [FRAME_BITS-1:0] rx_frame,
  output logic                  cs,
  output logic                  sck,
  output logic                  sdi,
  input  logic                  sdo
);

  localparam logic [BIT_CNT_BITS-1:0]  LAST_BIT  = BIT_CNT_BITS'(FRAME_BITS - 1);
  localparam logic [HALF_CNT_BITS-1:0] HOLD_LAST = HALF_CNT_BITS'(CLK_DIV - 1);

  spi_master_state_t        state_q, state_d;
  logic [FRAME_BITS-1:0]    tx_q, tx_d;
  logic [FRAME_BITS-1:0]    rx_q, rx_d;
  logic [FRAME_BITS-1:0]    rx_frame_q, rx_frame_d;
  logic [BIT_CNT_BITS-1:0]  bit_cnt_q, bit_cnt_d;
  logic [HALF_CNT_BITS-1:0] hold_cnt_q, hold_cnt_d;
  logic                     cs_q, cs_d;
  logic                     done_q, done_d;
  logic                     sck_en, rise_en, fall_en;

  assign sck_en = (state_q == SHIFT);

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk     (clk),
    .reset   (reset),
    .en      (sck_en),
    .sck     (sck),
    .rise_en (rise_en),
    .fall_en (fall_en)
  );

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rx_frame_d = rx_frame_q;
    bit_cnt_d  = bit_cnt_q;
    hold_cnt_d = hold_cnt_q;
    cs_d       = cs_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          tx_d      = {command, databyte1, databyte2};
          rx_d      = '0;
          bit_cnt_d = '0;
          cs_d      = 1'b1;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        // The receiver samples sdi on this same rising edge.
        if (rise_en) begin
          rx_d = {rx_q[FRAME_BITS-2:0], sdo};
        end
        // Next bit is presented as sck returns low. After the last bit the
        // shift empties tx, so sdi idles at 0 between frames.
        if (fall_en) begin
          tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
          if (bit_cnt_q == LAST_BIT) begin
            hold_cnt_d = '0;
            state_d    = HOLD;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          cs_d       = 1'b0;
          done_d     = 1'b1;
          rx_frame_d = rx_q;
          state_d    = IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      default: begin
        cs_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_q       <= '0;
      rx_q       <= '0;
      rx_frame_q <= '0;
      bit_cnt_q  <= '0;
      hold_cnt_q <= '0;
      cs_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rx_frame_q <= rx_frame_d;
      bit_cnt_q  <= bit_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      cs_q       <= cs_d;
      done_q     <= done_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign done     = done_q;
  assign rx_frame = rx_frame_q;
  assign cs       = cs_q;
  // The MSB of the tx shift register is a flop output, so sdi is registered.
  assign sdi      = tx_q[FRAME_BITS-1];

endmodule

// File: tb/tb_spi_frame_master.sv
// -----------------------------------------------------------------------------
// tb_spi_frame_master
// Self-checking bench for spi_frame_master. Two instances (CLK_DIV=4 and
// CLK_DIV=1) share the clock, reset and data inputs; sel chooses which one is
// requested and observed. Each frame's expected tx/rx words go into a
// scoreboard queue at request time and are popped when done is seen.
// -----------------------------------------------------------------------------
module tb_spi_frame_master;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       req4, req1;
  logic [7:0] cmd, db1, db2;
  logic [1:0] sdo_mode;  // 0: loopback sdo=sdi, 1: tied high, 2: tied low
  logic       sel;       // 0: observe CLK_DIV=4 instance, 1: CLK_DIV=1

  logic        ready4, done4, cs4, sck4, sdi4, sdo4;
  logic        ready1, done1, cs1, sck1, sdi1, sdo1;
  logic [23:0] rx4, rx1;

  assign sdo4 = (sdo_mode == 2'd0) ? sdi4 : (sdo_mode == 2'd1);
  assign sdo1 = (sdo_mode == 2'd0) ? sdi1 : (sdo_mode == 2'd1);

  spi_frame_master #(.CLK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .req(req4),
    .command(cmd), .databyte1(db1), .databyte2(db2),
    .ready(ready4), .done(done4), .rx_frame(rx4),
    .cs(cs4), .sck(sck4), .sdi(sdi4), .sdo(sdo4)
  );

  spi_frame_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1),
    .command(cmd), .databyte1(db1), .databyte2(db2),
    .ready(ready1), .done(done1), .rx_frame(rx1),
    .cs(cs1), .sck(sck1), .sdi(sdi1), .sdo(sdo1)
  );

  logic        o_ready, o_done, o_cs, o_sck, o_sdi;
  logic [23:0] o_rx;
  assign o_ready = sel ? ready1 : ready4;
  assign o_done  = sel ? done1  : done4;
  assign o_cs    = sel ? cs1    : cs4;
  assign o_sck   = sel ? sck1   : sck4;
  assign o_sdi   = sel ? sdi1   : sdi4;
  assign o_rx    = sel ? rx1    : rx4;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;
  int last_done_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0]  c, b1, b2;
    bit          d1;        // use the CLK_DIV=1 instance
    logic [1:0]  mode;      // sdo source
    logic [23:0] exp_rx;
    bit          mid_req;   // disturb inputs and pulse req mid-frame
    bit          hold_req;  // keep req high through done (back-to-back)
  } vec_t;

  typedef struct {
    logic [23:0] tx;
    logic [23:0] rx;
  } sb_t;

  sb_t sb_q[$];

  task automatic run_frame(input vec_t v, input bit check_b2b);
    int n, d, rises, toggles, cs_cnt;
    logic [23:0] cap;
    logic prev_sck;
    bit ready_ok;
    sb_t e;
    d = v.d1 ? 1 : 4;
    sel = v.d1;
    sdo_mode = v.mode;
    cmd = v.c; db1 = v.b1; db2 = v.b2;
    check("ready_before_req", o_ready, 1);
    if (v.d1) req1 = 1'b1; else req4 = 1'b1;
    sb_q.push_back('{tx: {v.c, v.b1, v.b2}, rx: v.exp_rx});
    @(posedge clk);
    @(negedge clk);
    if (!v.hold_req) begin req4 = 1'b0; req1 = 1'b0; end
    check("cs_rise_t1", o_cs, 1);
    check("ready_fall_t1", o_ready, 0);
    check("sdi_msb_t1", o_sdi, v.c[7]);
    n = 1; rises = 0; toggles = 0; cs_cnt = 0; cap = '0;
    prev_sck = 1'b0; ready_ok = 1'b1;
    while (n < 2000) begin
      if (o_done) break;
      if (o_cs) cs_cnt++;
      if (o_ready) ready_ok = 1'b0;
      if (o_sck && !prev_sck) begin
        rises++;
        cap = {cap[22:0], o_sdi};
      end
      if (o_sck != prev_sck) toggles++;
      prev_sck = o_sck;
      if (v.mid_req && n == 60) begin
        cmd = ~v.c; db1 = ~v.b1; db2 = 8'h99;
        req4 = 1'b1;
      end
      if (v.mid_req && n == 61) req4 = 1'b0;
      @(negedge clk);
      n++;
    end
    check("done_seen", (n < 2000), 1);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    else e = '{tx: 24'hx, rx: 24'hx};
    check("period", n, 49 * d + 1);
    check("cs_high_cycles", cs_cnt, 49 * d);
    check("sck_rises", rises, 24);
    check("sck_toggles", toggles, 48);
    check("tx_bits", cap, e.tx);
    check("rx_frame", o_rx, e.rx);
    check("cs_low_at_done", o_cs, 0);
    check("ready_at_done", o_ready, 1);
    if (v.mid_req) check("ready_low_until_done", ready_ok, 1);
    if (check_b2b) check("b2b_done_spacing", cyc - last_done_cyc, 197);
    last_done_cyc = cyc;
    if (!v.hold_req) begin
      @(negedge clk);
      check("done_one_cycle", o_done, 0);
      check("idle_after_done_cs", o_cs, 0);
      check("idle_after_done_ready", o_ready, 1);
      check("rx_holds", o_rx, e.rx);
    end
  endtask

  vec_t vecs[7];

  initial begin
    int done_cnt;
    vec_t post;

    vecs[0] = '{8'hA5, 8'h3C, 8'h81, 1'b0, 2'd0, 24'hA53C81, 1'b0, 1'b0};
    vecs[1] = '{8'h12, 8'h34, 8'h56, 1'b0, 2'd0, 24'h123456, 1'b0, 1'b0};
    vecs[2] = '{8'h12, 8'h34, 8'h56, 1'b0, 2'd1, 24'hFFFFFF, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 8'h00, 8'hFF, 1'b1, 2'd2, 24'h000000, 1'b0, 1'b0};
    vecs[4] = '{8'h5A, 8'hC3, 8'h7E, 1'b0, 2'd0, 24'h5AC37E, 1'b1, 1'b0};
    vecs[5] = '{8'h01, 8'h80, 8'hFF, 1'b0, 2'd0, 24'h0180FF, 1'b0, 1'b1};
    vecs[6] = '{8'hFE, 8'h7F, 8'h00, 1'b0, 2'd1, 24'hFFFFFF, 1'b0, 1'b0};

    reset = 1'b1; req4 = 1'b0; req1 = 1'b0;
    cmd = '0; db1 = '0; db2 = '0; sdo_mode = 2'd0; sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs4", cs4, 0);
    check("rst_sck4", sck4, 0);
    check("rst_sdi4", sdi4, 0);
    check("rst_done4", done4, 0);
    check("rst_ready4", ready4, 1);
    check("rst_rx4", rx4, 0);
    check("rst_cs1_sck1", {cs1, sck1, sdi1, done1}, 0);
    check("rst_ready1", ready1, 1);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i], (i == 6));
    end

    // Idle period with req low: no stray frame from the mid-frame request.
    repeat (10) @(negedge clk);
    check("no_extra_frame_cs", cs4, 0);
    check("no_extra_frame_ready", ready4, 1);

    // Reset in the middle of bit 10.
    sel = 1'b0; sdo_mode = 2'd0;
    cmd = 8'hC3; db1 = 8'h3C; db2 = 8'h5A;
    req4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req4 = 1'b0;
    repeat (80) @(negedge clk);
    check("pre_abort_cs", cs4, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_cs", cs4, 0);
    check("abort_sck", sck4, 0);
    check("abort_ready", ready4, 1);
    check("abort_rx", rx4, 0);
    check("abort_done", done4, 0);
    reset = 1'b0;
    done_cnt = 0;
    repeat (300) begin
      @(negedge clk);
      if (done4) done_cnt++;
    end
    check("no_done_after_abort", done_cnt, 0);

    post = '{8'h3C, 8'hA5, 8'h18, 1'b0, 2'd0, 24'h3CA518, 1'b0, 1'b0};
    run_frame(post, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/spi_frame_master.md
# spi_frame_master

Transmit end of the 3-byte SPI command frame that the FPGA's `spi` receiver decodes into `command`, `databyte1` and `databyte2`. On request, it serializes one 24-bit frame onto `cs`/`sck`/`sdi` and captures the 24 bits returned on `sdo`. It drives the graphics card from an on-board controller or loopback harness, and acts as the bus-functional driver in system benches.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per `sck` half-period; legal range 1..255.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  1  frame request; accepted on a cycle with `req && ready`.
- `command`  in  8  first byte sent.
- `databyte1`  in  8  second byte sent.
- `databyte2`  in  8  third byte sent.
- `ready`  out  1  high only in IDLE.
- `done`  out  1  one-cycle pulse when a frame completes.
- `rx_frame`  out  24  bits captured from `sdo`, first-received bit at [23]; updated only at frame completion.
- `cs`  out  1  chip select, active high for the whole frame.
- `sck`  out  1  serial clock, idle low.
- `sdi`  out  1  serial data to the receiver, MSB first.
- `sdo`  in  1  serial data from the receiver.

## Operation
- Mode 0 framing:
  - `sck` idles low.
  - `sdi` changes only while `sck` is low.
  - The receiver samples on the `sck` rising edge.
  - The master samples `sdo` on the same rising edge.
- On accept, {command, databyte1, databyte2} is latched into a 24-bit shift register. Later input changes have no effect on the frame.
- States:
  - IDLE: `cs`=0, `sck`=0, `ready`=1. Accept goes to SHIFT.
  - SHIFT: 24 bits. Each bit has a low half of CLK_DIV cycles, then a high half of CLK_DIV cycles. After bit 23 goes to HOLD.
  - HOLD: `cs`=1, `sck`=0 for CLK_DIV cycles, then goes to IDLE.
- `req` outside IDLE is ignored; there is no queueing.
- Bit counter: 5 bits, 0..23. Half-period counter: 8 bits, counts 0..CLK_DIV-1, then wraps to 0.
- `rx_frame` is loaded from the receive shift register on the cycle that HOLD leaves for IDLE.
- Reset values:
  - `cs`=0, `sck`=0, `sdi`=0, `done`=0, `ready`=1, `rx_frame`=0.
  - Shift registers, counters and state are all 0 / IDLE.
- Reset mid-frame: abort. `cs` and `sck` are 0 on the cycle after `reset` is sampled high. `done` does not pulse. `rx_frame` keeps its reset value 0.

## Timing
Let accept occur at clock edge T, and D = CLK_DIV.
- Cycle T+1:
  - `cs` rises.
  - `sdi` = bit 23 of the frame (`command[7]`).
  - `ready` falls.
- Bit i (i=0 is the MSB):
  - `sck` is low for cycles T+1+2iD .. T+iD·2+D.
  - `sck` is high for the following D cycles.
  - `sdo` is sampled on the clock edge at which the registered `sck` goes 1.
- `sdi` for the next bit is updated on the same edge that returns `sck` to 0.
- HOLD occupies cycles T+1+48D .. T+48D+D.
- At cycle T+1+49D:
  - `cs`=0, `ready`=1, `done`=1 for exactly one cycle.
  - `rx_frame` is valid and holds until the next completion.
- Frame period from accept to `done` is 49D+1 cycles. With D=4 this is 197 cycles.
- Back-to-back: `req` high during the `done` cycle is accepted. `cs` is then low for exactly one cycle between frames.
- `cs`, `sck` and `sdi` are all registered outputs, with no combinational path from `req`.

## Structure
- Package `spi_pkg` holds:
  - `FRAME_BITS` = 24;
  - `BYTE_BITS` = 8;
  - the state enum `spi_master_state_t` {IDLE, SHIFT, HOLD}.
- The receiver shares `FRAME_BITS` from this package.
- Sub-module `spi_sck_gen` contains the half-period counter. It emits a one-cycle `rise_en` and a one-cycle `fall_en` strobe, plus registered `sck`. It is enabled only in SHIFT.
- The top level contains the FSM, the TX/RX shift registers and the bit counter.

## Test plan
- D=4, frame {0xA5, 0x3C, 0x81}:
  - `sdi` sampled at each `sck` rise reads 0xA53C81 in order;
  - `cs` is high for exactly 196 cycles;
  - `done` occurs 197 cycles after accept.
- Loopback with `sdo` tied to `sdi`, frame {0x12, 0x34, 0x56}: `rx_frame`=0x123456 at `done`. With `sdo` tied to 1, `rx_frame`=0xFFFFFF.
- D=1, frame {0xFF, 0x00, 0xFF}: `sck` toggles every cycle with 24 rises; `done` occurs 50 cycles after accept.
- Change inputs and pulse `req` mid-frame:
  - the transmitted frame is unchanged;
  - there is no second frame;
  - `ready` stays 0 until `done`.
- `req` held high across `done`: the second frame starts; `cs` is low for exactly 1 cycle; two `done` pulses occur 197 cycles apart (D=4).
- Assert `reset` at bit 10:
  - the cycle after, `cs`=0, `sck`=0, `ready`=1, `rx_frame`=0;
  - there is no `done` pulse;
  - a subsequent frame runs correctly.
